// File: rtl/connect_pkg.sv
// Shared connect-suite helpers: width-generic saturating/wrapping adder and lane slicing.
package connect_pkg;

    localparam int unsigned MAX_W = 64;

    // Operands are zero-extended to MAX_W by the caller; only the low 'width' bits are meaningful.
    function automatic logic [MAX_W-1:0] sat_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             sat,
        input int unsigned      width
    );
        logic [MAX_W:0] w_sum;
        logic [MAX_W:0] w_mask;
        w_sum  = {1'b0, a} + {1'b0, b};
        w_mask = ({{MAX_W{1'b0}}, 1'b1} << width) - {{MAX_W{1'b0}}, 1'b1};
        if (sat && w_sum[width]) begin
            sat_add = w_mask[MAX_W-1:0];
        end else begin
            sat_add = w_sum[MAX_W-1:0] & w_mask[MAX_W-1:0];
        end
    endfunction

    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/connect_crossing_stage.sv
// One crossing stage: token registers plus the acc + B[IDX] adder feeding them.
module connect_crossing_stage
    import connect_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 4,
    parameter int unsigned IDX    = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_flush,
    input  logic                    i_load,
    input  logic                    i_valid,
    input  logic [WIDTH-1:0]        i_a,
    input  logic [WIDTH-1:0]        i_acc,
    input  logic [STAGES*WIDTH-1:0] i_taps,
    input  logic [STAGES*WIDTH-1:0] i_b,
    input  logic                    i_sat,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_a,
    output logic [WIDTH-1:0]        o_acc,
    output logic [STAGES*WIDTH-1:0] o_taps,
    output logic [STAGES*WIDTH-1:0] o_b,
    output logic                    o_sat
);

    localparam int unsigned LO = lane_lo(IDX, WIDTH);

    logic                    r_valid;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_acc;
    logic [STAGES*WIDTH-1:0] r_taps;
    logic [STAGES*WIDTH-1:0] r_b;
    logic                    r_sat;

    logic [WIDTH-1:0]        w_sum;
    logic [STAGES*WIDTH-1:0] w_taps;

    assign w_sum = WIDTH'(sat_add(MAX_W'(i_acc), MAX_W'(i_b[LO +: WIDTH]), i_sat, WIDTH));

    always_comb begin
        w_taps             = i_taps;
        w_taps[LO +: WIDTH] = w_sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_acc   <= '0;
            r_taps  <= '0;
            r_b     <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= i_valid;
            end
            // Data only moves with a real token so held outputs stay stable across bubbles.
            if (i_load && i_valid) begin
                r_a    <= i_a;
                r_acc  <= w_sum;
                r_taps <= w_taps;
                r_b    <= i_b;
                r_sat  <= i_sat;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_acc   = r_acc;
    assign o_taps  = r_taps;
    assign o_b     = r_b;
    assign o_sat   = r_sat;

endmodule

// File: rtl/connect_crossing_pipe.sv
// Pipelined chain of crossing stages with a combinational ready chain and occupancy count.
module connect_crossing_pipe
    import connect_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 4,
    localparam int unsigned OCC_W = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    io_flush,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [WIDTH-1:0]        io_in_a,
    input  logic [STAGES*WIDTH-1:0] io_in_b,
    input  logic                    io_in_sat,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [WIDTH-1:0]        io_out_a,
    output logic [WIDTH-1:0]        io_out_acc,
    output logic [STAGES*WIDTH-1:0] io_out_taps,
    output logic [OCC_W-1:0]        io_occupancy
);

    logic [STAGES-1:0]                   w_v;
    logic [STAGES-1:0][WIDTH-1:0]        w_a;
    logic [STAGES-1:0][WIDTH-1:0]        w_acc;
    logic [STAGES-1:0][STAGES*WIDTH-1:0] w_taps;
    logic [STAGES-1:0][STAGES*WIDTH-1:0] w_b;
    logic [STAGES-1:0]                   w_sat;
    logic [STAGES-1:0]                   w_adv;
    logic                                w_accept;
    logic [OCC_W-1:0]                    w_occ;
    logic                                w_unused;

    // Stage k may load if any stage at or below it is empty, or the sink is draining.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign w_adv[k] = io_out_ready | ~(&w_v[STAGES-1:k]);
    end

    assign io_in_ready = w_adv[0] & ~io_flush & reset_n;
    assign w_accept    = io_in_valid & io_in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            connect_crossing_stage #(
                .WIDTH (WIDTH),
                .STAGES(STAGES),
                .IDX   (k)
            ) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .i_flush(io_flush),
                .i_load (w_adv[k]),
                .i_valid(w_accept),
                .i_a    (io_in_a),
                .i_acc  (io_in_a),
                .i_taps ('0),
                .i_b    (io_in_b),
                .i_sat  (io_in_sat),
                .o_valid(w_v[k]),
                .o_a    (w_a[k]),
                .o_acc  (w_acc[k]),
                .o_taps (w_taps[k]),
                .o_b    (w_b[k]),
                .o_sat  (w_sat[k])
            );
        end else begin : g_next
            connect_crossing_stage #(
                .WIDTH (WIDTH),
                .STAGES(STAGES),
                .IDX   (k)
            ) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .i_flush(io_flush),
                .i_load (w_adv[k]),
                .i_valid(w_v[k-1]),
                .i_a    (w_a[k-1]),
                .i_acc  (w_acc[k-1]),
                .i_taps (w_taps[k-1]),
                .i_b    (w_b[k-1]),
                .i_sat  (w_sat[k-1]),
                .o_valid(w_v[k]),
                .o_a    (w_a[k]),
                .o_acc  (w_acc[k]),
                .o_taps (w_taps[k]),
                .o_b    (w_b[k]),
                .o_sat  (w_sat[k])
            );
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_v[i]);
        end
    end

    assign io_occupancy = w_occ;
    assign io_out_valid = w_v[STAGES-1];
    assign io_out_a     = w_a[STAGES-1];
    assign io_out_acc   = w_acc[STAGES-1];
    assign io_out_taps  = w_taps[STAGES-1];

    // The last stage's addends and mode have no consumer.
    assign w_unused = ^{w_b[STAGES-1], w_sat[STAGES-1]};

endmodule
